product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 85 ++++++++
 tb/tb_product_accumulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Signed 64-bit product accumulator; emits one sum per ACC_LEN products.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [63:0] product,
  input  logic        productValid,
  output logic        productReady,
  output logic [63:0] accumulation,
  output logic [3:0]  termCount,
  output logic        resultValid,
  input  logic        resultReady,
  output logic        overflow,
  output logic        accessError
);

  localparam logic ACCUM = 1'b0;
  localparam logic DONE  = 1'b1;
  localparam logic [3:0] LAST = 4'(ACC_LEN - 1);

  logic        state;
  logic [63:0] sum;
  logic [63:0] nxt;
  logic        ovf;

  assign productReady = (state == ACCUM);
  assign resultValid  = (state == DONE);

  always_comb begin
    sum = accumulation + product;
    ovf = (accumulation[63] == product[63]) &&
          (sum[63] != accumulation[63]);
    nxt = sum;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    if (ovf)
      nxt = accumulation[63] ? {1'b1, 63'd0} : {1'b0, {63{1'b1}}};
`else
    nxt = sum;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACCUM;
      accumulation <= '0;
      termCount    <= '0;
      overflow     <= 1'b0;
      accessError  <= 1'b0;
    end else if (clear) begin
      state        <= ACCUM;
      accumulation <= '0;
      termCount    <= '0;
      overflow     <= 1'b0;
      accessError  <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          accessError <= 1'b0;
          if (productValid) begin
            accumulation <= nxt;
            termCount    <= termCount + 4'd1;
            overflow     <= overflow | ovf;
            if (termCount == LAST)
              state <= DONE;
          end
        end
        DONE: begin
          // a product offered here is dropped, even alongside resultReady
          accessError <= productValid;
          if (resultReady) begin
            state        <= ACCUM;
            accumulation <= '0;
            termCount    <= '0;
            overflow     <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with ACC_LEN=4.
// Reference model tracks the block with plain integer arithmetic.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [63:0] product = '0;
  logic        productValid = 1'b0;
  logic        productReady;
  logic [63:0] accumulation;
  logic [3:0]  termCount;
  logic        resultValid;
  logic        resultReady = 1'b0;
  logic        overflow;
  logic        accessError;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.ACC_LEN(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .product(product), .productValid(productValid),
    .productReady(productReady), .accumulation(accumulation),
    .termCount(termCount), .resultValid(resultValid),
    .resultReady(resultReady), .overflow(overflow),
    .accessError(accessError)
  );

  always #5 clk = ~clk;

  // reference model: count of terms, full flag, signed sum
  longint m_acc;
  int     m_cnt;
  bit     m_done, m_ovf, m_err;

  always @(posedge clk or posedge reset) begin : mdl
    longint s;
    bit     o;
    longint p;
    if (reset) begin
      m_acc <= 0; m_cnt <= 0; m_done <= 0; m_ovf <= 0; m_err <= 0;
    end else if (clear) begin
      m_acc <= 0; m_cnt <= 0; m_done <= 0; m_ovf <= 0; m_err <= 0;
    end else if (m_done) begin
      m_err <= productValid;
      if (resultReady) begin
        m_acc <= 0; m_cnt <= 0; m_done <= 0; m_ovf <= 0;
      end
    end else begin
      m_err <= 0;
      if (productValid) begin
        p = longint'(product);
        s = m_acc + p;
        o = (m_acc < 0) == (p < 0) && (s < 0) != (m_acc < 0);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        if (o) s = (m_acc < 0) ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF;
`endif
        m_acc <= s;
        m_cnt <= m_cnt + 1;
        m_ovf <= m_ovf | o;
        if (m_cnt + 1 == 4) m_done <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_acc", accumulation, 64'(m_acc));
      chk("m_cnt", 64'(termCount), 64'(m_cnt));
      chk("m_rv", 64'(resultValid), 64'(m_done));
      chk("m_pr", 64'(productReady), 64'(!m_done));
      chk("m_ovf", 64'(overflow), 64'(m_ovf));
      chk("m_err", 64'(accessError), 64'(m_err));
    end
  end

  task automatic drive(input bit pv, input longint p,
                       input bit rr, input bit clr);
    productValid = pv;
    product = 64'(p);
    resultReady = rr;
    clear = clr;
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_acc", accumulation, 64'd0);
    chk("rst_cnt", 64'(termCount), 64'd0);
    chk("rst_rv", 64'(resultValid), 64'd0);
    chk("rst_pr", 64'(productReady), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // full block
    drive(1, 64'd2614916801295, 0, 0);
    drive(1, -2008, 0, 0);
    drive(1, -263875, 0, 0);
    drive(1, 123456789, 0, 0);
    chk("blk_acc", accumulation, 64'd2615039992201);
    chk("blk_cnt", 64'(termCount), 64'd4);
    chk("blk_rv", 64'(resultValid), 64'd1);

    // rejections while DONE
    for (int i = 0; i < 3; i++) begin
      drive(1, 77, 0, 0);
      chk("rej_err", 64'(accessError), 64'd1);
      chk("rej_acc", accumulation, 64'd2615039992201);
    end
    drive(0, 0, 1, 0);
    chk("rel_acc", accumulation, 64'd0);
    chk("rel_rv", 64'(resultValid), 64'd0);
    chk("rel_pr", 64'(productReady), 64'd1);
    drive(0, 0, 0, 0);
    chk("rel_err", 64'(accessError), 64'd0);

    // signed overflow
    drive(1, 64'h7FFFFFFFFFFFFFFF, 0, 0);
    drive(1, 1, 0, 0);
    chk("ovf_flag", 64'(overflow), 64'd1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("ovf_acc", accumulation, 64'h7FFFFFFFFFFFFFFF);
`else
    chk("ovf_acc", accumulation, 64'h8000000000000000);
`endif
    // clear overrides a simultaneous accept
    drive(1, 5, 0, 1);
    chk("clr_acc", accumulation, 64'd0);
    chk("clr_cnt", 64'(termCount), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);

    // negative terms, no overflow
    for (int i = 0; i < 4; i++) drive(1, -1, 0, 0);
    chk("neg_acc", accumulation, 64'hFFFFFFFFFFFFFFFC);
    chk("neg_ovf", 64'(overflow), 64'd0);
    chk("neg_rv", 64'(resultValid), 64'd1);

    // product with resultReady in DONE is rejected, not carried over
    drive(1, 9, 1, 0);
    chk("rr_err", 64'(accessError), 64'd1);
    chk("rr_cnt", 64'(termCount), 64'd0);
    drive(1, 7, 0, 0);
    chk("nxt_acc", accumulation, 64'd7);
    chk("nxt_cnt", 64'(termCount), 64'd1);

    // asynchronous reset mid-block
    drive(1, 3, 0, 0);
    productValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_acc", accumulation, 64'd0);
    chk("ar_cnt", 64'(termCount), 64'd0);
    chk("ar_rv", 64'(resultValid), 64'd0);
    chk("ar_pr", 64'(productReady), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 9, 0, 0);
    chk("ar_first", accumulation, 64'd9);

    // clear while DONE with a product offered
    for (int i = 0; i < 3; i++) drive(1, 2, 0, 0);
    chk("dn_rv", 64'(resultValid), 64'd1);
    drive(1, 2, 0, 1);
    chk("dc_rv", 64'(resultValid), 64'd0);
    chk("dc_err", 64'(accessError), 64'd0);
    chk("dc_acc", accumulation, 64'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
